minmax_seq_ctrl: RTL
====================

# minmax_seq_ctrl

Sequential controller that finds the greatest and lowest of a burst of N operands using one shared magnitude comparator pair instead of a full N-way combinational comparator tree. A start pulse opens a burst. Operands stream in one per accepted valid/ready handshake. After the last operand the block reports:
- the max and min values,
- the index of their first occurrence,
- whether either extreme was tied.

It sits in front of the datapath as the resource-sharing replacement for wide parallel compare logic.

## Interface
Parameters:
- W, 32, operand width in bits
- N, 4, operands per burst; legal range 1 to 256
- IW, $clog2(N) with a minimum of 1, index width (derived, not overridden)

Ports:
- clk_21  in  1  clock; all state changes on the rising edge
- rst_21  in  1  synchronous, active-high reset
- start_21  in  1  opens a burst; sampled only in IDLE
- in_valid_21  in  1  operand on in_data_21 is valid
- in_data_21  in  W  operand
- in_ready_21  out  1  high only in LOAD; a word is accepted when in_valid_21 and in_ready_21 are both high at an edge
- busy_21  out  1  high in LOAD and DONE
- done_21  out  1  one-cycle pulse; results are complete
- max_21  out  W  greatest operand of the last burst
- min_21  out  W  lowest operand of the last burst
- max_idx_21  out  IW  index (0-based, arrival order) of the first occurrence of the max
- min_idx_21  out  IW  index of the first occurrence of the min
- max_tie_21  out  1  at least two operands equal the max
- min_tie_21  out  1  at least two operands equal the min

## Operation
States:
- IDLE: in_ready_21=0, busy_21=0.
  - start_21=1 goes to LOAD and clears the word counter cnt.
- LOAD: in_ready_21=1, busy_21=1.
  - Each accepted word increments cnt.
  - The edge that accepts word index N-1 moves the FSM to DONE.
- DONE: in_ready_21=0, busy_21=1, done_21=1 for exactly this cycle.
  - Goes unconditionally to IDLE.

Update rule when word d is accepted at index k:
- k=0:
  - max_21 = min_21 = d
  - both indices = 0
  - both tie flags = 0
- k>0, d > max_21: max_21 = d, max_idx_21 = k, max_tie_21 = 0.
- k>0, d == max_21: max_tie_21 = 1; value and index unchanged.
- k>0, d < min_21: min_21 = d, min_idx_21 = k, min_tie_21 = 0.
- k>0, d == min_21: min_tie_21 = 1; value and index unchanged.
- The max and min updates are evaluated independently in the same cycle.

Result holding:
- Results hold their values from DONE until the edge that accepts word 0 of the next burst.
- Between bursts the results are stable and readable.

Boundary conditions:
- start_21 in LOAD or DONE is ignored; it does not restart the burst.
- in_valid_21 outside LOAD is ignored; no word is consumed.
- in_valid_21 low in LOAD stalls the burst indefinitely; there is no timeout.
- N=1: the single word gives max = min, both indices 0, both ties 0, and DONE follows.
- All N words equal: both indices 0 and both ties 1.
- Reset mid-burst aborts the burst. No done_21 pulse is produced.

Reset values (applied at any rst_21 edge):
- state IDLE, cnt 0
- in_ready_21, busy_21, done_21 = 0
- max_21, min_21 = 0
- both indices 0, both ties 0

## Timing
- start_21 high at edge t gives in_ready_21 high from t+1.
- Accept edges for words 0 to N-1 may be back-to-back.
- The last word is accepted at edge e. Results are final after e, and done_21 is high in the cycle following e.
- After DONE, in_ready_21 is low in the next cycle; the earliest restart is start_21 sampled in the IDLE cycle.
- Minimum burst time is N+2 cycles from start to IDLE.
- Outputs are registered only; no combinational path from in_data_21 to any output.

## Configuration
- SIGNED_CMP_EN defined: operands and stored extremes are compared as two's-complement signed W-bit values.
- Undefined (default): comparison is unsigned.
- All other behaviour is identical in both builds.

## Test plan
- Basic burst, N=4, unsigned: words 5,9,2,7 back-to-back.
  - Required: done_21 in the cycle after the 4th accept, max=9, max_idx=1, min=2, min_idx=2, ties 0.
- Ties: words 3,8,8,3.
  - Required: max=8, max_idx=1, max_tie=1, min=3, min_idx=0, min_tie=1.
- Stall and protocol violations, words 1,4,0,2:
  - in_valid_21 low for 3 cycles between words 1 and 2;
  - start_21 pulsed mid-LOAD;
  - in_valid_21 high in IDLE before start.
  - Required: only 4 words consumed, results max=4 idx1, min=0 idx2, a single done pulse.
- Reset mid-burst: assert rst_21 after 2 accepts.
  - Required: all outputs at reset values next cycle, no done_21.
  - A fresh burst of 6,6,6,6 then gives idx 0/0 and ties 1/1.
- Signedness: words 32'hFFFF_FFFF, 1, 0, 2.
  - Without SIGNED_CMP_EN: max=FFFF_FFFF idx0, min=0 idx2.
  - With SIGNED_CMP_EN: max=2 idx3, min=FFFF_FFFF idx0.
- Results held: after DONE, idle for 10 cycles, then start a new burst.
  - Required: results unchanged until the first accept of the new burst.

Source files
------------

// File: rtl/minmax_seq_ctrl.sv
// Burst min/max finder sharing one comparator pair across N operands.
// Define SIGNED_CMP_EN for two's-complement compares; default is unsigned.
module minmax_seq_ctrl #(
    parameter int W = 32,
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_21,
    input  logic          rst_21,
    input  logic          start_21,
    input  logic          in_valid_21,
    input  logic [W-1:0]  in_data_21,
    output logic          in_ready_21,
    output logic          busy_21,
    output logic          done_21,
    output logic [W-1:0]  max_21,
    output logic [W-1:0]  min_21,
    output logic [IW-1:0] max_idx_21,
    output logic [IW-1:0] min_idx_21,
    output logic          max_tie_21,
    output logic          min_tie_21
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  max_q, max_d;
    logic [W-1:0]  min_q, min_d;
    logic [IW-1:0] max_idx_q, max_idx_d;
    logic [IW-1:0] min_idx_q, min_idx_d;
    logic          max_tie_q, max_tie_d;
    logic          min_tie_q, min_tie_d;

    logic accept;
    logic last;
    logic gt_max;
    logic lt_min;
    logic eq_max;
    logic eq_min;

    // ready is only ever high in LOAD, so it doubles as the state qualifier
    assign accept = ready_q & in_valid_21;
    assign last   = (cnt_q == IW'(N - 1));
    assign eq_max = (in_data_21 == max_q);
    assign eq_min = (in_data_21 == min_q);

`ifdef SIGNED_CMP_EN
    assign gt_max = $signed(in_data_21) > $signed(max_q);
    assign lt_min = $signed(in_data_21) < $signed(min_q);
`else
    assign gt_max = in_data_21 > max_q;
    assign lt_min = in_data_21 < min_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        max_d     = max_q;
        min_d     = min_q;
        max_idx_d = max_idx_q;
        min_idx_d = min_idx_q;
        max_tie_d = max_tie_q;
        min_tie_d = min_tie_q;
        unique case (state_q)
            IDLE: begin
                if (start_21) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_q == '0) begin
                        max_d     = in_data_21;
                        min_d     = in_data_21;
                        max_idx_d = '0;
                        min_idx_d = '0;
                        max_tie_d = 1'b0;
                        min_tie_d = 1'b0;
                    end else begin
                        if (gt_max) begin
                            max_d     = in_data_21;
                            max_idx_d = cnt_q;
                            max_tie_d = 1'b0;
                        end else if (eq_max) begin
                            max_tie_d = 1'b1;
                        end
                        if (lt_min) begin
                            min_d     = in_data_21;
                            min_idx_d = cnt_q;
                            min_tie_d = 1'b0;
                        end else if (eq_min) begin
                            min_tie_d = 1'b1;
                        end
                    end
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == LOAD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk_21) begin
        if (rst_21) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            max_q     <= '0;
            min_q     <= '0;
            max_idx_q <= '0;
            min_idx_q <= '0;
            max_tie_q <= 1'b0;
            min_tie_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            max_q     <= max_d;
            min_q     <= min_d;
            max_idx_q <= max_idx_d;
            min_idx_q <= min_idx_d;
            max_tie_q <= max_tie_d;
            min_tie_q <= min_tie_d;
        end
    end

    assign in_ready_21 = ready_q;
    assign busy_21     = busy_q;
    assign done_21     = done_q;
    assign max_21      = max_q;
    assign min_21      = min_q;
    assign max_idx_21  = max_idx_q;
    assign min_idx_21  = min_idx_q;
    assign max_tie_21  = max_tie_q;
    assign min_tie_21  = min_tie_q;

endmodule
